// File: rtl/traffic_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_controller_pkg
// Purpose  : Shared states, light encodings and default intervals.
// Revision : 1.0
// ============================================================================
package traffic_controller_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_MG   = 3'd1,
        S_MGX  = 3'd2,
        S_MY   = 3'd3,
        S_SG   = 3'd4,
        S_SY   = 3'd5
    } state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [4:0] DEF_T_MAIN = 5'd6;
    localparam logic [4:0] DEF_T_EXT  = 5'd3;
    localparam logic [4:0] DEF_T_YEL  = 5'd2;
    localparam logic [4:0] DEF_T_SIDE = 5'd5;

    function automatic logic [2:0] main_light_of(input state_e s);
        case (s)
            S_MG, S_MGX: main_light_of = GRN;
            S_MY:        main_light_of = YEL;
            default:     main_light_of = RED;
        endcase
    endfunction

    function automatic logic [2:0] side_light_of(input state_e s);
        case (s)
            S_SG:    side_light_of = GRN;
            S_SY:    side_light_of = YEL;
            default: side_light_of = RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_controller_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : req_latch
// Purpose  : Two-flop synchronizer feeding a sticky request bit.
// Revision : 1.0
// ============================================================================
module req_latch (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    input  logic clear_i,
    output logic latched_o
);

    logic meta_q;
    logic sync_q;
    logic latched_q;

    // A request arriving in the same cycle as a clear must not be lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            if (sync_q) begin
                latched_q <= 1'b1;
            end else if (clear_i) begin
                latched_q <= 1'b0;
            end
        end
    end

    assign latched_o = latched_q;

endmodule
`default_nettype wire

// File: rtl/traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_controller
// Purpose  : Main/side street light sequencer with sensor and walk requests.
// Revision : 1.0
// ============================================================================
module traffic_controller
    import traffic_controller_pkg::*;
#(
    parameter logic [4:0] T_MAIN = DEF_T_MAIN,
    parameter logic [4:0] T_EXT  = DEF_T_EXT,
    parameter logic [4:0] T_YEL  = DEF_T_YEL,
    parameter logic [4:0] T_SIDE = DEF_T_SIDE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic       start_timer,
    output logic [4:0] value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [4:0] phase_seconds
);

    state_e     state_q;
    state_e     state_d;
    logic       advance_d;
    logic [4:0] interval_d;
    logic [1:0] guard_q;
    logic       start_timer_q;
    logic [4:0] value_q;
    logic [2:0] main_light_q;
    logic [2:0] side_light_q;
    logic       walk_q;
    logic [4:0] phase_seconds_q;

    logic sensor_latched;
    logic walk_latched;
    logic req_pending;
    logic sg_entry;

    assign sg_entry    = (state_q == S_SG) && start_timer_q;
    assign req_pending = sensor_latched | walk_latched;

    req_latch u_sensor_latch (
        .clk_i     (clock),
        .rst_i     (reset),
        .async_i   (sensor),
        .clear_i   (sg_entry),
        .latched_o (sensor_latched)
    );

    req_latch u_walk_latch (
        .clk_i     (clock),
        .rst_i     (reset),
        .async_i   (walk_request),
        .clear_i   (sg_entry),
        .latched_o (walk_latched)
    );

    // guard_q counts cycles since entry; expired is honoured once it reaches 2.
    always_comb begin
        state_d   = state_q;
        advance_d = 1'b0;
        if (state_q == S_INIT) begin
            state_d   = S_MG;
            advance_d = 1'b1;
        end else if ((guard_q == 2'd2) && expired) begin
            advance_d = 1'b1;
            case (state_q)
                S_MG, S_MGX: state_d = req_pending ? S_MY : S_MGX;
                S_MY:        state_d = S_SG;
                S_SG:        state_d = S_SY;
                S_SY:        state_d = S_MG;
                default:     state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        case (state_d)
            S_MG:    interval_d = T_MAIN;
            S_MGX:   interval_d = T_EXT;
            S_MY:    interval_d = T_YEL;
            S_SG:    interval_d = T_SIDE;
            S_SY:    interval_d = T_YEL;
            default: interval_d = 5'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_INIT;
            guard_q         <= 2'd0;
            start_timer_q   <= 1'b0;
            value_q         <= 5'd0;
            main_light_q    <= RED;
            side_light_q    <= RED;
            walk_q          <= 1'b0;
            phase_seconds_q <= 5'd0;
        end else begin
            state_q       <= state_d;
            start_timer_q <= advance_d;
            main_light_q  <= main_light_of(state_d);
            side_light_q  <= side_light_of(state_d);

            if (advance_d) begin
                guard_q <= 2'd0;
                value_q <= interval_d;
                walk_q  <= (state_d == S_SG) && walk_latched;
            end else if (guard_q != 2'd2) begin
                guard_q <= guard_q + 2'd1;
            end

            // Zero through the whole start cycle; a coinciding tick is dropped.
            if (advance_d || start_timer_q) begin
                phase_seconds_q <= 5'd0;
            end else if (one_hz_enable && (phase_seconds_q != 5'd31)) begin
                phase_seconds_q <= phase_seconds_q + 5'd1;
            end
        end
    end

    assign start_timer   = start_timer_q;
    assign value         = value_q;
    assign main_light    = main_light_q;
    assign side_light    = side_light_q;
    assign walk          = walk_q;
    assign phase_seconds = phase_seconds_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_controller
// Purpose  : Randomized scoreboard bench for traffic_controller.
// Revision : 1.0
// ============================================================================
module tb_traffic_controller;

    logic       clock;
    logic       reset;
    logic       sensor;
    logic       walk_request;
    logic       expired;
    logic       one_hz_enable;
    logic       start_timer;
    logic [4:0] value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [4:0] phase_seconds;

    traffic_controller dut (
        .clock         (clock),
        .reset         (reset),
        .sensor        (sensor),
        .walk_request  (walk_request),
        .expired       (expired),
        .one_hz_enable (one_hz_enable),
        .start_timer   (start_timer),
        .value         (value),
        .main_light    (main_light),
        .side_light    (side_light),
        .walk          (walk),
        .phase_seconds (phase_seconds)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef enum int {P_INIT, P_MAIN, P_MAIN_EXT, P_MAIN_YEL, P_SIDE, P_SIDE_YEL} phase_t;

    typedef struct packed {
        logic       st;
        logic [4:0] val;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wk;
        logic [4:0] ps;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the observable situation in the cycle after the next edge.
    phase_t m_ph;
    int     m_age;
    logic   m_start;
    int     m_val;
    logic   m_walk;
    int     m_secs;
    logic   m_slat, m_wlat;
    logic   s_old, s_new, w_old, w_new;
    int     rnd_dly;

    function automatic int interval_of(input phase_t p);
        case (p)
            P_MAIN:     return 6;
            P_MAIN_EXT: return 3;
            P_MAIN_YEL: return 2;
            P_SIDE:     return 5;
            P_SIDE_YEL: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [2:0] main_of(input phase_t p);
        if (p == P_MAIN || p == P_MAIN_EXT) return 3'b001;
        if (p == P_MAIN_YEL) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] side_of(input phase_t p);
        if (p == P_SIDE) return 3'b001;
        if (p == P_SIDE_YEL) return 3'b010;
        return 3'b100;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic h,
                              input logic s, input logic w);
        logic   adv, clr, s_sync, w_sync;
        phase_t nxt;
        if (r) begin
            m_ph = P_INIT; m_age = 0; m_start = 1'b0; m_val = 0; m_walk = 1'b0;
            m_secs = 0; m_slat = 1'b0; m_wlat = 1'b0;
            s_old = 1'b0; s_new = 1'b0; w_old = 1'b0; w_new = 1'b0;
            return;
        end
        s_sync = s_old;
        w_sync = w_old;
        adv = (m_ph == P_INIT) || (m_age >= 2 && e);
        case (m_ph)
            P_INIT:             nxt = P_MAIN;
            P_MAIN, P_MAIN_EXT: nxt = (m_slat || m_wlat) ? P_MAIN_YEL : P_MAIN_EXT;
            P_MAIN_YEL:         nxt = P_SIDE;
            P_SIDE:             nxt = P_SIDE_YEL;
            default:            nxt = P_MAIN;
        endcase
        if (adv) begin
            m_walk = (nxt == P_SIDE) && m_wlat;
            m_val  = interval_of(nxt);
        end
        if (adv || m_start) m_secs = 0;
        else if (h) m_secs = (m_secs < 31) ? m_secs + 1 : 31;
        clr    = (m_ph == P_SIDE) && m_start;
        m_slat = s_sync | (m_slat & ~clr);
        m_wlat = w_sync | (m_wlat & ~clr);
        s_old = s_new; s_new = s;
        w_old = w_new; w_new = w;
        m_start = adv;
        m_age   = adv ? 0 : m_age + 1;
        if (adv) m_ph = nxt;
    endtask

    function automatic exp_t expected();
        exp_t x;
        x.st  = m_start;
        x.val = m_val[4:0];
        x.ml  = main_of(m_ph);
        x.sl  = side_of(m_ph);
        x.wk  = m_walk;
        x.ps  = m_secs[4:0];
        return x;
    endfunction

    task automatic step(input logic r, input logic e, input logic h,
                        input logic s, input logic w);
        reset = r; expired = e; one_hz_enable = h; sensor = s; walk_request = w;
        model_edge(r, e, h, s, w);
        q.push_back(expected());
        if (r && $time > 0) begin
            #1;
            total++;
            if (main_light !== 3'b100 || side_light !== 3'b100 || walk !== 1'b0 || start_timer !== 1'b0) begin
                bad++;
                $display("FAIL reset_immediate: got main=%b side=%b walk=%b start=%b want main=100 side=100 walk=0 start=0",
                         main_light, side_light, walk, start_timer);
            end
        end
        @(negedge clock);
    endtask

    // mode 0: expired once age>=dly; mode 1: random level; mode 2: random delay per phase.
    task automatic run(input int n, input int mode, input int dly, input int hz_pct, input int req_pct);
        for (int i = 0; i < n; i++) begin
            logic e;
            if (m_age == 0) rnd_dly = $urandom_range(5, 0);
            if (mode == 0)      e = (m_age >= dly);
            else if (mode == 1) e = ($urandom_range(1, 0) == 1);
            else                e = (m_age >= rnd_dly);
            step(1'b0, e, ($urandom_range(99, 0) < hz_pct),
                 ($urandom_range(99, 0) < req_pct), ($urandom_range(99, 0) < req_pct));
        end
    endtask

    initial begin : monitor
        exp_t x, got;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {start_timer, value, main_light, side_light, walk, phase_seconds};
                total++;
                if (got !== x) begin
                    bad++;
                    $display("FAIL cycle_outputs t=%0t: got st=%b val=%0d main=%b side=%b walk=%b secs=%0d want st=%b val=%0d main=%b side=%b walk=%b secs=%0d",
                             $time, got.st, got.val, got.ml, got.sl, got.wk, got.ps,
                             x.st, x.val, x.ml, x.sl, x.wk, x.ps);
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        rnd_dly = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(40, 0, 3, 30, 0);
        run(300, 2, 0, 30, 4);
        run(120, 0, 40, 100, 0);
        run(80, 1, 0, 50, 20);

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_ph == P_SIDE_YEL && m_age == 1) found = 1'b1;
            else run(1, 0, 2, 30, 10);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_side_yellow: got no side-yellow phase within 300 cycles want one");
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(30, 0, 3, 30, 0);
        run(60, 0, 0, 50, 5);
        run(200, 2, 0, 40, 8);

        @(posedge clock);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
